ysyx_22050710_lsu_req: RTL
==========================

Name: ysyx_22050710_lsu_req

Overview:
- Data-SRAM request issuer inside the execute stage, directly upstream of the memory stage.
- Takes the EX memory command (load/store, op, address, store data) and drives the data-SRAM request channel (req/addr_ok handshake).
- Produces the EX ready_go so that an instruction reaches MEM only after its address phase is accepted. The memory stage then waits for data_ok.
- Guarantees at most one outstanding request, with payload held stable until accepted.

Parameters:
- WORD_WD, 64, GPR/address width.
- SRAM_DATA_WD, 64, data-SRAM data width; byte lanes = SRAM_DATA_WD/8.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low (asserted when 0).
- i_es_valid  in  1  EX holds a valid instruction.
- i_mem_ren  in  1  instruction is a load.
- i_mem_wen  in  1  instruction is a store.
- i_mem_op  in  3  [1:0] size (0=B,1=H,2=W,3=D); [2] unsigned-load flag, ignored here.
- i_addr  in  WORD_WD  x[rs1]+imm.
- i_wdata  in  WORD_WD  x[rs2] store data.
- i_ms_allowin  in  1  MEM can accept.
- o_es_ready_go  out  1  EX may hand over to MEM.
- o_misalign  out  1  address not aligned to size.
- o_data_sram_req  out  1  request valid.
- o_data_sram_wr  out  1  1=write, 0=read.
- o_data_sram_size  out  2  = i_mem_op[1:0] (latched).
- o_data_sram_addr  out  WORD_WD  byte address (latched).
- o_data_sram_wstrb  out  SRAM_DATA_WD/8  byte enables; 0 on reads.
- o_data_sram_wdata  out  SRAM_DATA_WD  lane-replicated store data.
- i_data_sram_addr_ok  in  1  slave accepted the address phase.

Behaviour:
- Reset (i_rst==0 at posedge):
  - state=IDLE, o_data_sram_req=0.
  - Payload registers cleared to 0; o_misalign=0.
  - No pending request survives reset, even one in REQ.
- mem = i_es_valid & (i_mem_ren|i_mem_wen).
- misalign = mem & (addr[0] for H | addr[1:0]!=0 for W | addr[2:0]!=0 for D). It is combinational from inputs.
- A misaligned command is never issued: o_es_ready_go=1 and no req. o_misalign flags it to the exception path.
- FSM states:
  - IDLE: if mem & !misalign & i_ms_allowin, latch payload and go to REQ. req rises the next cycle. Otherwise stay.
  - REQ: o_data_sram_req=1 with payload from registers, stable every cycle until addr_ok.
    - On addr_ok: if i_ms_allowin, go to IDLE; the EX->MEM fire happens this same cycle.
    - On addr_ok with !i_ms_allowin: go to SENT.
    - Without addr_ok: stay. req is never withdrawn, even if i_ms_allowin drops.
  - SENT: req=0. When i_ms_allowin, go to IDLE (fire). Never reissue.
- o_es_ready_go:
  - !mem or misalign: 1.
  - REQ & addr_ok: 1.
  - SENT: 1.
  - All other cases: 0 (including IDLE with a pending mem command, since its request has not gone out yet).
- Fire = i_es_valid & o_es_ready_go & i_ms_allowin. The upstream stage must not change the command while a request is in REQ or SENT.
- Write data and strobes:
  - Base masks: B=0x01, H=0x03, W=0x0F, D=0xFF.
  - wstrb = base_mask << addr[2:0], truncated to 8 bits.
  - wdata replication: B = 8 copies of wdata[7:0]; H = 4 copies of [15:0]; W = 2 copies of [31:0]; D = as-is.
  - Reads: wstrb=0, wdata=0.
- Back-to-back: an IDLE->REQ launch may occur the cycle after the previous fire. Turnaround is one cycle minimum per memory instruction.
- Single outstanding request: launch from IDLE requires i_ms_allowin=1. This guarantees MEM will be free to collect data_ok.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles with i_es_valid=1 and a store pending, then release. Required: req=0 during reset; req rises the 2nd cycle after release.
- Store byte: addr=0x8000_0005, op=0, wdata=0xAB, addr_ok immediate. Required: wstrb=0x20, wdata=0xABAB_ABAB_ABAB_ABAB, wr=1, size=0, ready_go=1 in the addr_ok cycle.
- Load with stalled slave: addr=0x8000_0010, op=3 (LD), addr_ok withheld 4 cycles. Required: req held 4+ cycles with addr constant; ready_go=0 until addr_ok; wstrb=0.
- ms_allowin drop: addr_ok arrives while i_ms_allowin=0. Required: enter SENT, req=0; ready_go=1 and exactly one request; fire when ms_allowin returns.
- Misaligned: SW at addr 0x8000_0002. Required: o_misalign=1, ready_go=1, req never asserted.
- Non-memory: i_es_valid=1, ren=wen=0. Required: ready_go=1 each cycle, req=0, FSM stays IDLE.

Source files
------------

// File: rtl/ysyx_22050710_lsu_req.sv
// Data-SRAM request issuer for the execute stage: launches one load/store address
// phase per memory instruction and holds EX until the slave accepts it.
module ysyx_22050710_lsu_req #(
   parameter int WORD_WD      = 64,
   parameter int SRAM_DATA_WD = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_es_valid,
   input  logic                      i_mem_ren,
   input  logic                      i_mem_wen,
   input  logic [2:0]                i_mem_op,
   input  logic [WORD_WD-1:0]        i_addr,
   input  logic [WORD_WD-1:0]        i_wdata,
   input  logic                      i_ms_allowin,
   output logic                      o_es_ready_go,
   output logic                      o_misalign,
   output logic                      o_data_sram_req,
   output logic                      o_data_sram_wr,
   output logic [1:0]                o_data_sram_size,
   output logic [WORD_WD-1:0]        o_data_sram_addr,
   output logic [SRAM_DATA_WD/8-1:0] o_data_sram_wstrb,
   output logic [SRAM_DATA_WD-1:0]   o_data_sram_wdata,
   input  logic                      i_data_sram_addr_ok
);
   localparam int LANES = SRAM_DATA_WD / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SENT = 2'd2
   } state_e;

   state_e                  state_r;
   state_e                  state_nxt_s;
   logic                    mem_s;
   logic                    misalign_s;
   logic                    launch_s;
   logic                    ready_go_s;
   logic                    req_r;
   logic                    wr_r;
   logic [1:0]              size_r;
   logic [WORD_WD-1:0]      addr_r;
   logic [LANES-1:0]        wstrb_r;
   logic [SRAM_DATA_WD-1:0] wdata_r;
   logic                    unused_s;

   function automatic logic misalign_f(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd1:    misalign_f = off[0];
         2'd2:    misalign_f = |off[1:0];
         2'd3:    misalign_f = |off;
         default: misalign_f = 1'b0;
      endcase
   endfunction

   function automatic logic [LANES-1:0] strb_f(input logic [1:0] size, input logic [2:0] off);
      logic [LANES-1:0] base;
      case (size)
         2'd0:    base = LANES'(8'h01);
         2'd1:    base = LANES'(8'h03);
         2'd2:    base = LANES'(8'h0f);
         default: base = LANES'(8'hff);
      endcase
      strb_f = base << off;
   endfunction

   function automatic logic [SRAM_DATA_WD-1:0] rep_f(input logic [1:0] size,
                                                     input logic [WORD_WD-1:0] wd);
      case (size)
         2'd0:    rep_f = {(SRAM_DATA_WD/8){wd[7:0]}};
         2'd1:    rep_f = {(SRAM_DATA_WD/16){wd[15:0]}};
         2'd2:    rep_f = {(SRAM_DATA_WD/32){wd[31:0]}};
         default: rep_f = SRAM_DATA_WD'(wd);
      endcase
   endfunction

   assign unused_s   = i_mem_op[2];
   assign mem_s      = i_es_valid & (i_mem_ren | i_mem_wen);
   assign misalign_s = mem_s & misalign_f(i_mem_op[1:0], i_addr[2:0]);

   // Next-state and ready_go; launching needs MEM free so data_ok always has a taker.
   always_comb begin
      state_nxt_s = state_r;
      launch_s    = 1'b0;
      ready_go_s  = ~mem_s | misalign_s;
      case (state_r)
         IDLE: begin
            if (mem_s && !misalign_s && i_ms_allowin) begin
               launch_s    = 1'b1;
               state_nxt_s = REQ;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         REQ: begin
            if (i_data_sram_addr_ok) begin
               ready_go_s  = 1'b1;
               state_nxt_s = i_ms_allowin ? IDLE : SENT;
            end else begin
               state_nxt_s = REQ;
            end
         end
         SENT: begin
            ready_go_s  = 1'b1;
            state_nxt_s = i_ms_allowin ? IDLE : SENT;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State and request payload; payload is captured only at launch so it stays stable in REQ.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_r <= IDLE;
         req_r   <= 1'b0;
         wr_r    <= 1'b0;
         size_r  <= 2'd0;
         addr_r  <= '0;
         wstrb_r <= '0;
         wdata_r <= '0;
      end else begin
         state_r <= state_nxt_s;
         req_r   <= (state_nxt_s == REQ);
         if (launch_s) begin
            wr_r    <= i_mem_wen;
            size_r  <= i_mem_op[1:0];
            addr_r  <= i_addr;
            wstrb_r <= i_mem_wen ? strb_f(i_mem_op[1:0], i_addr[2:0]) : '0;
            wdata_r <= i_mem_wen ? rep_f(i_mem_op[1:0], i_wdata) : '0;
         end
      end
   end

   assign o_es_ready_go     = ready_go_s;
   assign o_misalign        = misalign_s & i_rst;
   assign o_data_sram_req   = req_r;
   assign o_data_sram_wr    = wr_r;
   assign o_data_sram_size  = size_r;
   assign o_data_sram_addr  = addr_r;
   assign o_data_sram_wstrb = wstrb_r;
   assign o_data_sram_wdata = wdata_r;

endmodule
